// File: rtl/updown_step_monitor.sv
// Step checker for a WIDTH-bit up/down counter: flags wraps, direction changes and bad steps.
// Define UDC_ERR_CNT_EN to build the saturating step-error counter; otherwise err_count is tied to 0.
module updown_step_monitor #(
  parameter int WIDTH      = 4,
  parameter int WRAP_CNT_W = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  Mode,
  input  logic [WIDTH-1:0]      count_in,
  input  logic                  mon_en,
  input  logic                  clr,
  output logic                  wrap_up,
  output logic                  wrap_down,
  output logic                  dir_change,
  output logic                  step_err,
  output logic                  err_sticky,
  output logic [WRAP_CNT_W-1:0] wrap_count,
  output logic [WRAP_CNT_W-1:0] err_count
);

  typedef enum logic {INIT, TRACK} state_t;

  localparam logic [WIDTH-1:0]      CNT_ONE = 1;
  localparam logic [WRAP_CNT_W-1:0] EVT_ONE = 1;

  state_t                state_q;
  logic [WIDTH-1:0]      prev_count_q;
  logic                  prev_mode_q;
  logic                  wrap_up_q, wrap_down_q, dir_change_q, step_err_q, err_sticky_q;
  logic [WRAP_CNT_W-1:0] wrap_cnt_q;

  logic [WIDTH-1:0]      exp_d;
  logic                  track_d, wrap_up_d, wrap_down_d, dir_change_d, step_err_d;

  always_comb begin
    exp_d        = prev_mode_q ? prev_count_q + CNT_ONE : prev_count_q - CNT_ONE;
    track_d      = mon_en && (state_q == TRACK);
    step_err_d   = track_d && (count_in != exp_d);
    // A bad step never counts as a wrap, even if it happens to land on 0 or max.
    wrap_up_d    = track_d && !step_err_d && prev_mode_q && (prev_count_q == '1);
    wrap_down_d  = track_d && !step_err_d && !prev_mode_q && (prev_count_q == '0);
    dir_change_d = track_d && (Mode != prev_mode_q);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= INIT;
      prev_count_q <= '0;
      prev_mode_q  <= 1'b0;
      wrap_up_q    <= 1'b0;
      wrap_down_q  <= 1'b0;
      dir_change_q <= 1'b0;
      step_err_q   <= 1'b0;
      err_sticky_q <= 1'b0;
      wrap_cnt_q   <= '0;
    end else begin
      wrap_up_q    <= wrap_up_d;
      wrap_down_q  <= wrap_down_d;
      dir_change_q <= dir_change_d;
      step_err_q   <= step_err_d;

      if (!mon_en) begin
        state_q <= INIT;
      end else begin
        // Resync to the observed value every enabled edge, so one bad step gives one error.
        state_q      <= TRACK;
        prev_count_q <= count_in;
        prev_mode_q  <= Mode;
      end

      if (clr) begin
        err_sticky_q <= 1'b0;
        wrap_cnt_q   <= '0;
      end else begin
        if (step_err_d)
          err_sticky_q <= 1'b1;
        if ((wrap_up_d || wrap_down_d) && (wrap_cnt_q != '1))
          wrap_cnt_q <= wrap_cnt_q + EVT_ONE;
      end
    end
  end

`ifdef UDC_ERR_CNT_EN
  logic [WRAP_CNT_W-1:0] err_cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n)
      err_cnt_q <= '0;
    else if (clr)
      err_cnt_q <= '0;
    else if (step_err_d && (err_cnt_q != '1))
      err_cnt_q <= err_cnt_q + EVT_ONE;
  end

  assign err_count = err_cnt_q;
`else
  assign err_count = '0;
`endif

  assign wrap_up    = wrap_up_q;
  assign wrap_down  = wrap_down_q;
  assign dir_change = dir_change_q;
  assign step_err   = step_err_q;
  assign err_sticky = err_sticky_q;
  assign wrap_count = wrap_cnt_q;

endmodule

// File: tb/tb_updown_step_monitor.sv
// Directed bench for updown_step_monitor: default-width instance plus a 2-bit counter instance
// sharing the same stimulus so counter saturation can be seen.
module tb_updown_step_monitor;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       Mode = 1'b0;
  logic [3:0] count_in = '0;
  logic       mon_en = 1'b0;
  logic       clr = 1'b0;

  logic       wrap_up, wrap_down, dir_change, step_err, err_sticky;
  logic [7:0] wrap_count, err_count;
  logic       b_wrap_up, b_wrap_down, b_dir_change, b_step_err, b_err_sticky;
  logic [1:0] b_wrap_count, b_err_count;

  int errors = 0;
  int checks = 0;

`ifdef UDC_ERR_CNT_EN
  localparam int ERR_ONE = 1;
`else
  localparam int ERR_ONE = 0;
`endif

  updown_step_monitor #(.WIDTH(4), .WRAP_CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .Mode(Mode), .count_in(count_in), .mon_en(mon_en), .clr(clr),
    .wrap_up(wrap_up), .wrap_down(wrap_down), .dir_change(dir_change), .step_err(step_err),
    .err_sticky(err_sticky), .wrap_count(wrap_count), .err_count(err_count)
  );

  updown_step_monitor #(.WIDTH(4), .WRAP_CNT_W(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .Mode(Mode), .count_in(count_in), .mon_en(mon_en), .clr(clr),
    .wrap_up(b_wrap_up), .wrap_down(b_wrap_down), .dir_change(b_dir_change), .step_err(b_step_err),
    .err_sticky(b_err_sticky), .wrap_count(b_wrap_count), .err_count(b_err_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // Apply one sample, clock it, and settle just after the edge for checking.
  task automatic step(input logic m, input logic [3:0] c, input logic en = 1'b1, input logic cl = 1'b0);
    Mode = m; count_in = c; mon_en = en; clr = cl;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_a"}, {wrap_up, wrap_down, dir_change, step_err, err_sticky, wrap_count, err_count}, 0);
    chk({tag, "_b"}, {b_wrap_up, b_wrap_down, b_dir_change, b_step_err, b_err_sticky,
                      b_wrap_count, b_err_count}, 0);
  endtask

  int sm_tab[6]  = '{1, 2, 3, 3, 3, 0};
  int big_tab[6] = '{1, 2, 3, 4, 5, 0};

  initial begin
    int cur;
    int wraps;
    logic wrapping;

    // Reset
    step(1'b1, 4'd0, 1'b1);
    step(1'b1, 4'd0, 1'b1);
    chk_all_zero("reset");
    rst_n = 1'b1;

    // 1: full up-count with one wrap
    for (int i = 0; i < 18; i++) begin
      step(1'b1, 4'(i));
      chk("t1_wrap_up", wrap_up, (i == 16));
      chk("t1_step_err", step_err, 0);
    end
    chk("t1_wrap_count", wrap_count, 1);
    chk("t1_err_sticky", err_sticky, 0);
    chk("t1_b_wrap_count", b_wrap_count, 1);

    // 2: direction change at 7
    for (int v = 2; v <= 6; v++) begin
      step(1'b1, 4'(v));
      chk("t2_dir_change_pre", dir_change, 0);
    end
    step(1'b0, 4'd7);
    chk("t2_dir_change", dir_change, 1);
    chk("t2_step_err_7", step_err, 0);
    step(1'b0, 4'd6);
    chk("t2_dir_change_post", dir_change, 0);
    chk("t2_step_err_6", step_err, 0);
    step(1'b0, 4'd5);
    chk("t2_step_err_5", step_err, 0);

    // 3: down-wrap
    for (int v = 4; v >= 0; v--) begin
      step(1'b0, 4'(v));
      chk("t3_wrap_down_pre", wrap_down, 0);
      chk("t3_step_err", step_err, 0);
    end
    step(1'b0, 4'd15);
    chk("t3_wrap_down", wrap_down, 1);
    chk("t3_wrap_count", wrap_count, 2);
    step(1'b0, 4'd14);
    chk("t3_wrap_down_post", wrap_down, 0);

    // 4: injected jump 5 -> 9
    step(1'b1, 4'd13);
    chk("t4_dir_change", dir_change, 1);
    chk("t4_step_err_13", step_err, 0);
    step(1'b1, 4'd14);
    step(1'b1, 4'd15);
    step(1'b1, 4'd0);
    chk("t4_wrap_up", wrap_up, 1);
    chk("t4_wrap_count", wrap_count, 3);
    chk("t4_b_wrap_count", b_wrap_count, 3);
    for (int v = 1; v <= 5; v++) step(1'b1, 4'(v));
    chk("t4_no_err_before", err_sticky, 0);
    step(1'b1, 4'd9);
    chk("t4_step_err", step_err, 1);
    chk("t4_err_sticky", err_sticky, 1);
    chk("t4_err_count", err_count, ERR_ONE);
    chk("t4_b_err_count", b_err_count, ERR_ONE);
    chk("t4_no_wrap", wrap_up, 0);
    step(1'b1, 4'd10);
    chk("t4_step_err_10", step_err, 0);
    step(1'b1, 4'd11);
    chk("t4_step_err_11", step_err, 0);
    chk("t4_err_sticky_hold", err_sticky, 1);
    chk("t4_err_count_hold", err_count, ERR_ONE);

    // 5: clr, then saturation on the 2-bit instance, then clr with a wrap
    step(1'b1, 4'd12, 1'b1, 1'b1);
    chk("t5_clr_wrap", wrap_count, 0);
    chk("t5_clr_sticky", err_sticky, 0);
    chk("t5_clr_errcnt", err_count, 0);
    chk("t5_clr_b_wrap", b_wrap_count, 0);
    cur = 12;
    wraps = 0;
    for (int s = 0; s < 120 && wraps < 6; s++) begin
      cur = (cur + 1) % 16;
      wrapping = (cur == 0);
      if (wrapping) wraps++;
      step(1'b1, 4'(cur), 1'b1, wrapping && (wraps == 6));
      chk("t5_wrap_up", wrap_up, wrapping);
      chk("t5_b_wrap_up", b_wrap_up, wrapping);
      if (wrapping) begin
        chk("t5_b_wrap_count", b_wrap_count, sm_tab[wraps-1]);
        chk("t5_wrap_count", wrap_count, big_tab[wraps-1]);
      end
    end
    chk("t5_wraps_seen", wraps, 6);
    clr = 1'b0;

    // 6: mid-run reset, capture after jump, then disable/re-enable
    rst_n = 1'b0;
    step(1'b1, 4'd1);
    chk_all_zero("t6_reset");
    rst_n = 1'b1;
    step(1'b1, 4'd12);
    chk("t6_capture_pulses", {wrap_up, wrap_down, dir_change, step_err}, 0);
    step(1'b1, 4'd13);
    chk("t6_step_err_13", step_err, 0);
    chk("t6_sticky", err_sticky, 0);
    step(1'b1, 4'd3, 1'b0);
    chk("t6_disabled_pulses", {wrap_up, wrap_down, dir_change, step_err}, 0);
    step(1'b1, 4'd8);
    chk("t6_recapture", step_err, 0);
    step(1'b1, 4'd9);
    chk("t6_step_err_9", step_err, 0);
    step(1'b1, 4'd11);
    chk("t6_step_err_11", step_err, 1);
    chk("t6_sticky_set", err_sticky, 1);
    step(1'b1, 4'd12, 1'b0);
    chk("t6_sticky_hold", err_sticky, 1);
    chk("t6_errcnt_hold", err_count, ERR_ONE);
    chk("t6_no_pulse_off", step_err, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/updown_step_monitor.md
# updown_step_monitor

Downstream checker for the 4-bit up/down counter. Samples the counter's `Out` value and its `Mode` input every clock. Flags up-wraps, down-wraps and direction changes, and flags any step that is not exactly ±1 in the commanded direction. Keeps saturating event counters and a sticky error for bench and debug readback.

## Interface
- `WIDTH`, default 4: width of the monitored count.
- `WRAP_CNT_W`, default 8: width of the wrap and error counters.

- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: reset, synchronous, active-low.
- `Mode` input 1: the counter's direction input (1 = up, 0 = down), tapped in parallel.
- `count_in` input WIDTH: the counter's `Out`.
- `mon_en` input 1: monitor enable.
- `clr` input 1: synchronous clear of counters and sticky error.
- `wrap_up` output 1: one-cycle pulse on a max→0 step while counting up.
- `wrap_down` output 1: one-cycle pulse on a 0→max step while counting down.
- `dir_change` output 1: one-cycle pulse when `Mode` differs from its previous sample.
- `step_err` output 1: one-cycle pulse when `count_in` differs from the expected value.
- `err_sticky` output 1: set on any `step_err`; cleared only by `clr` or reset.
- `wrap_count` output WRAP_CNT_W: saturating count of `wrap_up` plus `wrap_down` events.
- `err_count` output WRAP_CNT_W: saturating count of `step_err` events (see Configuration).

## Operation
- Registers:
  - `prev_count`: `count_in` sampled at the previous edge.
  - `prev_mode`: `Mode` sampled at the previous edge; this is the direction the counter used to produce the current `count_in`.
- Expected value: `exp = prev_mode ? prev_count+1 : prev_count-1`, modulo 2^WIDTH.
- States: INIT, TRACK.
  - INIT: entered on reset, and on any edge with `mon_en`=0.
    - An edge with `mon_en`=1 in INIT captures `prev_count` and `prev_mode`.
    - No checks and no pulses in INIT. Next state is TRACK.
  - TRACK with `mon_en`=1, at every edge:
    - Compare `count_in` against `exp`.
    - Update `prev_count` and `prev_mode` unconditionally. After an error the monitor resynchronises to the actual value, so one bad step produces exactly one `step_err`.
  - TRACK with `mon_en`=0: go to INIT. Counters and `err_sticky` hold. No pulses.
- Event rules in TRACK:
  - `count_in != exp`: `step_err` pulses. `wrap_up` and `wrap_down` are suppressed that cycle.
  - Match, `prev_mode`=1, `prev_count`=2^WIDTH-1: `wrap_up` pulses.
  - Match, `prev_mode`=0, `prev_count`=0: `wrap_down` pulses.
  - `Mode != prev_mode`: `dir_change` pulses. This is independent of the error and wrap decisions.
- Counter arithmetic:
  - `wrap_count` and `err_count` are unsigned, increment by 1 per event, and saturate at 2^WRAP_CNT_W-1. They never roll over.
- `clr` handling:
  - `clr`=1 zeroes `wrap_count`, `err_count` and `err_sticky` at that edge. `clr` has priority over any same-edge increment or set.
  - Pulses from that edge still assert. State and the prev registers are unaffected.
- Reset (`rst_n`=0 at an edge), including mid-run:
  - All outputs become 0, state becomes INIT, and `prev_count`/`prev_mode` become 0.
  - Reset has priority over `clr` and `mon_en`.

## Timing
- All outputs are registered.
- A step visible on `count_in` before edge k is reported on the outputs during the cycle after edge k. Latency is 1 clock.
- Pulses last exactly one clock. Back-to-back events give back-to-back pulses.
- After reset release or re-enable:
  - The first edge with `mon_en`=1 only captures.
  - The earliest possible pulse is driven after the second such edge.
- Counters and `err_sticky` reflect an edge's event in the same cycle as its pulse.

## Configuration
- Macro: `UDC_ERR_CNT_EN`.
- Defined: `err_count` is implemented as specified.
- Undefined:
  - No error-counter register is built and `err_count` is driven constant 0.
  - `step_err` and `err_sticky` are unchanged.

## Test plan
1. Reset 2 cycles, then `mon_en`=1, `Mode`=1, `count_in` 0,1,…,15,0,1. Required:
   - exactly one `wrap_up`, on the 15→0 step;
   - `wrap_count`=1, `step_err` never asserts, `err_sticky`=0.
2. Up-count to 7, then `Mode`=0 for the next edge; `count_in` continues 7,6,5. Required:
   - one `dir_change` pulse, latency 1;
   - no `step_err`.
3. `Mode`=0 and `count_in` 2,1,0,15,14. Required:
   - one `wrap_down` on 0→15;
   - `wrap_count` increments by 1.
4. Up-count with an injected 5→9 jump, then 10,11. Required:
   - exactly one `step_err`, `err_sticky`=1;
   - `err_count`=1 with `UDC_ERR_CNT_EN`, 0 without;
   - 9→10 accepted.
5. `WRAP_CNT_W`=2: run 5 up-wraps. Required:
   - `wrap_count` reads 1,2,3,3,3;
   - then `clr` coincident with a 6th wrap gives `wrap_count`=0 while the `wrap_up` pulse is still seen.
6. Mid-run `rst_n`=0 for 1 cycle, then `count_in` jumps to 12 and continues 13. Required:
   - all outputs 0 after reset;
   - no `step_err` on the 12 capture;
   - 12→13 checked and passes.
